// File: rtl/shift_sequencer_pkg.sv
// Shared types for shift_sequencer: the mc10141 mode select and the sequencer state encoding.
// Also holds the mapping from sequencer state to the mode driven onto the shift chain.
package shift_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 36;
  localparam int DEFAULT_CNTW  = 6;
  localparam int SLICE_W       = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'b00,
    SHIFTL = 2'b01,
    SHIFTR = 2'b10,
    HOLD   = 2'b11
  } tMode141;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } tShiftSeqState;

  // The chain idles in HOLD. It only loads or shifts while the sequencer is busy.
  function automatic tMode141 modeForState(tShiftSeqState st, logic shiftRight);
    tMode141 m;
    m = HOLD;
    if (st == S_LOAD) begin
      m = LOAD;
    end else if (st == S_SHIFT) begin
      m = shiftRight ? SHIFTR : SHIFTL;
    end
    return m;
  endfunction

endpackage

// File: rtl/shift_sequencer_mc10141.sv
// mc10141: 4-bit universal shift register slice with parallel load, shift both ways and hold.
// Bit 0 is the most significant bit. SHIFTL moves data toward bit 3; SHIFTR moves data toward bit 0.
module mc10141
  import shift_sequencer_pkg::*;
(
  input  logic       clk,
  input  tMode141    sel,
  input  logic       d0In,
  input  logic       d3In,
  input  logic [0:3] dIn,
  output logic [0:3] q
);

  logic [0:3] reg_q;

  always_ff @(posedge clk) begin
    case (sel)
      LOAD:    reg_q <= dIn;
      SHIFTL:  reg_q <= {d0In, reg_q[0:2]};
      SHIFTR:  reg_q <= {reg_q[1:3], d3In};
      default: reg_q <= reg_q;
    endcase
  end

  assign q = reg_q;

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: loads a word into a chain of mc10141 slices, then shifts it count places.
// Define SHIFT_SEQUENCER_ROTATE_EN to let a latched rot=1 recirculate shiftOut as the fill bit.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNTW  = DEFAULT_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [CNTW-1:0]  count,
  input  logic             fill,
  input  logic             rot,
  input  logic [0:WIDTH-1] loadData,
  output logic [0:WIDTH-1] q,
  output logic             shiftOut,
  output tMode141          mode,
  output logic             busy,
  output logic             done
);

  localparam int SLICES = WIDTH / SLICE_W;

  tShiftSeqState    state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             dir_q;
  logic             fill_q;
  logic [0:WIDTH-1] data_q;
  tMode141          mode_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             fillBit;
  logic [0:WIDTH-1] chainData;

  // A command is accepted only between operations. The count loads here and counts down in SHIFT.
  always_comb begin
    accept  = start && (state_q == S_IDLE || state_q == S_DONE);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = (cnt_q != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = start ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) cnt_d = count;
  end

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic rot_q;
`endif

  // The outputs are registered from the next state, so mode, busy and done line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      data_q  <= '0;
      mode_q  <= HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        dir_q  <= dir;
        fill_q <= fill;
        data_q <= loadData;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        rot_q  <= rot;
`endif
      end
      mode_q <= modeForState(state_d, dir_q);
      busy_q <= (state_d == S_LOAD) || (state_d == S_SHIFT);
      done_q <= (state_d == S_DONE);
    end
  end

  assign shiftOut = dir_q ? q[0] : q[WIDTH-1];

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  assign fillBit = rot_q ? shiftOut : fill_q;
`else
  logic unusedRot;
  assign unusedRot = rot;
  assign fillBit   = fill_q;
`endif

  // The chain has no reset of its own. While reset is high, it loads zeros.
  assign mode      = reset ? LOAD : mode_q;
  assign chainData = reset ? '0 : data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Each slice takes its serial inputs from its neighbours. The fill bit enters at the two outer ends.
  for (genvar s = 0; s < SLICES; s++) begin : gSlice
    logic d0;
    logic d3;
    if (s == 0) begin : gFirst
      assign d0 = fillBit;
    end else begin : gChainL
      assign d0 = q[SLICE_W*s-1];
    end
    if (s == SLICES-1) begin : gLast
      assign d3 = fillBit;
    end else begin : gChainR
      assign d3 = q[SLICE_W*s+SLICE_W];
    end
    mc10141 uSlice (
      .clk  (clk),
      .sel  (mode),
      .d0In (d0),
      .d3In (d3),
      .dIn  (chainData[SLICE_W*s +: SLICE_W]),
      .q    (q[SLICE_W*s +: SLICE_W])
    );
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: table vectors, randomized ops against a reference model,
// and hand-written sequences for reset, back-to-back starts and ignored starts.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int W  = 36;
  localparam int CW = 6;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          dir;
  logic [CW-1:0] count;
  logic          fill;
  logic          rot;
  logic [0:W-1]  loadData;
  logic [0:W-1]  q;
  logic          shiftOut;
  tMode141       mode;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [35:0] ld;
    logic        d;
    logic [5:0]  n;
    logic        f;
    logic        r;
    logic [35:0] expQ;
  } vecT;

  vecT vecs[9];

  shift_sequencer #(.WIDTH(W), .CNTW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dir      (dir),
    .count    (count),
    .fill     (fill),
    .rot      (rot),
    .loadData (loadData),
    .q        (q),
    .shiftOut (shiftOut),
    .mode     (mode),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] rand36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[35:0];
  endfunction

  // Bit 0 of the DUT word is its MSB. So SHIFTL moves the value toward the numeric LSB,
  // and SHIFTR moves it toward the numeric MSB.
  function automatic logic [35:0] refShift(input logic [35:0] v0, input logic d, input int n,
                                           input logic f, input logic r);
    logic [35:0] v;
    logic        lost;
    logic        fb;
    v = v0;
    for (int i = 0; i < n; i++) begin
      lost = d ? v[35] : v[0];
      fb   = (ROT_EN && r) ? lost : f;
      if (!d) v = {fb, v[35:1]};
      else    v = {v[34:0], fb};
    end
    return v;
  endfunction

  // Presents a command for one clock and then scrambles the inputs. Only the latched values may matter.
  task automatic applyStimulus(input logic [35:0] ld, input logic d, input logic [5:0] n,
                               input logic f, input logic r);
    loadData = ld;
    dir      = d;
    count    = n;
    fill     = f;
    rot      = r;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    loadData = rand36();
    dir      = 1'($urandom());
    count    = 6'($urandom());
    fill     = 1'($urandom());
    rot      = 1'($urandom());
  endtask

  // Called right after the edge that sampled start. Returns in the done cycle.
  task automatic waitDone(input string name, input logic [35:0] ld, input logic d, input int n,
                          input logic [35:0] expQ, input int pulseAt);
    int lat;
    int busyCnt;
    lat     = -1;
    busyCnt = 0;
    for (int c = 1; c <= 80; c++) begin
      if (busy) busyCnt++;
      if (c == pulseAt) begin
        start    = 1'b1;
        loadData = rand36();
        dir      = ~d;
        count    = 6'd1;
        fill     = ~fill;
      end
      tick();
      start = 1'b0;
      if (c == 1) checkOutput({name, "/loaded"}, q, ld);
      if (done) begin
        lat = c;
        break;
      end
    end
    checkOutput({name, "/doneLatency"}, 36'(lat), 36'(n + 1));
    checkOutput({name, "/busyCycles"}, 36'(busyCnt), 36'(n + 1));
    checkOutput({name, "/finalQ"}, q, expQ);
    checkOutput({name, "/shiftOut"}, {35'b0, shiftOut}, {35'b0, (d ? expQ[35] : expQ[0])});
    checkOutput({name, "/busyAtDone"}, {35'b0, busy}, 36'b0);
    checkOutput({name, "/modeAtDone"}, 36'(mode), 36'(HOLD));
  endtask

  initial begin
    logic [35:0] ld;
    logic [35:0] ldB;
    logic        d;
    logic        f;
    logic        r;
    int          n;
    int          doneSeen;

    reset    = 1'b1;
    start    = 1'b0;
    dir      = 1'b0;
    count    = '0;
    fill     = 1'b0;
    rot      = 1'b0;
    loadData = '0;

    tick();
    checkOutput("reset/modeDuringReset", 36'(mode), 36'(LOAD));
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset/q", q, 36'o0);
    checkOutput("reset/busy", {35'b0, busy}, 36'b0);
    checkOutput("reset/done", {35'b0, done}, 36'b0);
    checkOutput("reset/mode", 36'(mode), 36'(HOLD));
    checkOutput("reset/shiftOut", {35'b0, shiftOut}, 36'b0);

    vecs[0] = '{36'o400000000000, 1'b0, 6'd3,  1'b0, 1'b0, 36'o040000000000};
    vecs[1] = '{36'o000000000000, 1'b1, 6'd1,  1'b1, 1'b0, 36'o000000000001};
    vecs[2] = '{36'o123456701234, 1'b0, 6'd0,  1'b0, 1'b0, 36'o123456701234};
    vecs[3] = '{36'o400000000000, 1'b1, 6'd1,  1'b0, 1'b1, (ROT_EN ? 36'o000000000001 : 36'o0)};
    vecs[4] = '{36'o777000000000, 1'b1, 6'd6,  1'b0, 1'b0, 36'o700000000000};
    vecs[5] = '{36'o000000000777, 1'b0, 6'd3,  1'b1, 1'b0, 36'o700000000077};
    vecs[6] = '{36'o123456701234, 1'b0, 6'd40, 1'b1, 1'b0, 36'o777777777777};
    vecs[7] = '{36'o765432107654, 1'b1, 6'd63, 1'b0, 1'b0, 36'o0};
    vecs[8] = '{36'o123456701234, 1'b1, 6'd36, 1'b0, 1'b1, (ROT_EN ? 36'o123456701234 : 36'o0)};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].d, vecs[i].n, vecs[i].f, vecs[i].r);
      waitDone($sformatf("vec%0d", i), vecs[i].ld, vecs[i].d, int'(vecs[i].n), vecs[i].expQ, -1);
      tick();
      checkOutput($sformatf("vec%0d/donePulse", i), {35'b0, done}, 36'b0);
    end

    // Back-to-back: start in the done cycle must go straight into a new load.
    ld  = rand36();
    ldB = rand36();
    applyStimulus(ld, 1'b0, 6'd2, 1'b1, 1'b0);
    waitDone("b2bA", ld, 1'b0, 2, refShift(ld, 1'b0, 2, 1'b1, 1'b0), -1);
    applyStimulus(ldB, 1'b1, 6'd4, 1'b0, 1'b0);
    checkOutput("b2b/busyAfterStart", {35'b0, busy}, 36'b1);
    checkOutput("b2b/doneAfterStart", {35'b0, done}, 36'b0);
    waitDone("b2bB", ldB, 1'b1, 4, refShift(ldB, 1'b1, 4, 1'b0, 1'b0), -1);
    tick();

    // A start pulse during SHIFT changes neither the timing nor the result.
    ld = rand36();
    applyStimulus(ld, 1'b0, 6'd5, 1'b1, 1'b0);
    waitDone("ignStart", ld, 1'b0, 5, refShift(ld, 1'b0, 5, 1'b1, 1'b0), 3);
    tick();

    // Reset during the second of five shifts aborts the operation, and no done pulse follows.
    ld = 36'o525252525252;
    applyStimulus(ld, 1'b1, 6'd5, 1'b0, 1'b0);
    tick();
    checkOutput("abort/loaded", q, ld);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("abort/q", q, 36'o0);
    checkOutput("abort/busy", {35'b0, busy}, 36'b0);
    checkOutput("abort/done", {35'b0, done}, 36'b0);
    checkOutput("abort/modeDuringReset", 36'(mode), 36'(LOAD));
    reset = 1'b0;
    #1;
    checkOutput("abort/modeAfter", 36'(mode), 36'(HOLD));
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("abort/noDone", 36'(doneSeen), 36'(0));
    checkOutput("abort/idleBusy", {35'b0, busy}, 36'b0);
    checkOutput("abort/qHeld", q, 36'o0);

    // Randomized operations, some chained back-to-back from the done cycle.
    for (int i = 0; i < 40; i++) begin
      ld = rand36();
      d  = 1'($urandom());
      f  = 1'($urandom());
      r  = 1'($urandom());
      n  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 12));
      applyStimulus(ld, d, 6'(n), f, r);
      waitDone($sformatf("rand%0d", i), ld, d, n, refShift(ld, d, n, f, r), -1);
      if ($urandom_range(0, 1) == 0) begin
        tick();
        checkOutput($sformatf("rand%0d/donePulse", i), {35'b0, done}, 36'b0);
      end
    end

    // Reset with a non-zero q present. Start is also asserted in the first reset cycle, and reset wins.
    applyStimulus(36'o777777777777, 1'b0, 6'd0, 1'b0, 1'b0);
    waitDone("preReset", 36'o777777777777, 1'b0, 0, 36'o777777777777, -1);
    reset    = 1'b1;
    start    = 1'b1;
    loadData = 36'o111111111111;
    tick();
    start = 1'b0;
    checkOutput("reset2/qFirstEdge", q, 36'o0);
    checkOutput("reset2/modeDuringReset", 36'(mode), 36'(LOAD));
    checkOutput("reset2/busy", {35'b0, busy}, 36'b0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset2/q", q, 36'o0);
    checkOutput("reset2/done", {35'b0, done}, 36'b0);
    checkOutput("reset2/mode", 36'(mode), 36'(HOLD));
    tick();
    checkOutput("reset2/staysIdle", {35'b0, busy}, 36'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
